// File: rtl/counter_ext_pkg.sv
// ----------------------------------------------------------------------------
// counter_ext_pkg : mode and direction encodings for counter_ext  (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

package counter_ext_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/counter_ext_if.sv
// ----------------------------------------------------------------------------
// counter_ext_if : bit-bus, register and position-bus signals of counter_ext  (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

interface counter_ext_if #(
  parameter int WIDTH      = 32,
  parameter int STEP_WIDTH = 32
);

  logic                  enable_i;
  logic                  trigger_i;
  logic                  dir_i;
  logic [WIDTH-1:0]      START;
  logic                  START_WSTB;
  logic [STEP_WIDTH-1:0] STEP;
  logic                  STEP_WSTB;
  logic [WIDTH-1:0]      MIN;
  logic [WIDTH-1:0]      MAX;
  logic                  MODE;
  logic [WIDTH-1:0]      out_o;
  logic                  carry_o;
  logic                  ovf_o;

  modport master (
    output enable_i, trigger_i, dir_i, START, START_WSTB, STEP, STEP_WSTB,
           MIN, MAX, MODE,
    input  out_o, carry_o, ovf_o
  );

  modport slave (
    input  enable_i, trigger_i, dir_i, START, START_WSTB, STEP, STEP_WSTB,
           MIN, MAX, MODE,
    output out_o, carry_o, ovf_o
  );

endinterface

`default_nettype wire

// File: rtl/counter_ext_edge_detect.sv
// ----------------------------------------------------------------------------
// edge_detect : rising-edge detector with synchronous active-low clear  (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module edge_detect (
  input  wire logic clk_i,
  input  wire logic reset_n_i,
  input  wire logic d_i,
  output logic      re_o
);

  logic d_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign re_o = d_i & ~d_q;

endmodule

`default_nettype wire

// File: rtl/counter_ext.sv
// ----------------------------------------------------------------------------
// counter_ext : up/down counter with MIN/MAX limits, wrap/saturate, sticky overflow  (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module counter_ext
  import counter_ext_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int STEP_WIDTH = 32
) (
  input wire logic      clk_i,
  input wire logic      reset_n_i,
  counter_ext_if.slave  bus
);

  logic                  trig_re;
  logic                  en_re;
  logic [WIDTH-1:0]      out_q;
  logic [WIDTH-1:0]      out_d;
  logic                  carry_q;
  logic                  carry_d;
  logic                  ovf_q;
  logic [STEP_WIDTH-1:0] step_q;

  // Arithmetic at WIDTH+1 bits so sums and MIN+step cannot overflow
  logic [WIDTH:0] w_cur;
  logic [WIDTH:0] w_stp;
  logic [WIDTH:0] w_min;
  logic [WIDTH:0] w_max;
  logic [WIDTH:0] w_rng;
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_sub;
  logic [WIDTH:0] w_dn_lim;
  logic [WIDTH:0] w_up_wrap;
  logic [WIDTH:0] w_dn_wrap;

  edge_detect u_trig_edge (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .d_i       (bus.trigger_i),
    .re_o      (trig_re)
  );

  edge_detect u_en_edge (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .d_i       (bus.enable_i),
    .re_o      (en_re)
  );

  always_comb begin
    w_stp                   = '0;
    w_stp[STEP_WIDTH-1:0]   = step_q;
  end

  assign w_cur     = {1'b0, out_q};
  assign w_min     = {1'b0, bus.MIN};
  assign w_max     = {1'b0, bus.MAX};
  assign w_rng     = w_max - w_min + 1'b1;
  assign w_sum     = w_cur + w_stp;
  assign w_sub     = w_cur - w_stp;
  assign w_dn_lim  = w_min + w_stp;
  assign w_up_wrap = w_sum - w_rng;
  assign w_dn_wrap = w_sub + w_rng;

  always_comb begin
    out_d   = out_q;
    carry_d = 1'b0;
    if (bus.dir_i == DIR_UP) begin
      if (w_sum > w_max) begin
        if (bus.MODE == MODE_WRAP) begin
          out_d   = w_up_wrap[WIDTH-1:0];
          carry_d = 1'b1;
        end else begin
          out_d   = bus.MAX;
          carry_d = (out_q != bus.MAX);
        end
      end else begin
        out_d   = w_sum[WIDTH-1:0];
        carry_d = (bus.MODE == MODE_SAT) && (w_sum == w_max);
      end
    end else begin
      if (w_cur < w_dn_lim) begin
        if (bus.MODE == MODE_WRAP) begin
          out_d   = w_dn_wrap[WIDTH-1:0];
          carry_d = 1'b1;
        end else begin
          out_d   = bus.MIN;
          carry_d = (out_q != bus.MIN);
        end
      end else begin
        out_d   = w_sub[WIDTH-1:0];
        carry_d = (bus.MODE == MODE_SAT) && (w_sub == w_min);
      end
    end
  end

  // STEP_WSTB is independent of the load/count priority; a same-cycle count sees the old step
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      out_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      step_q  <= STEP_WIDTH'(1);
    end else begin
      if (bus.STEP_WSTB) begin
        step_q <= bus.STEP;
      end
      if (bus.START_WSTB || en_re) begin
        out_q   <= bus.START;
        carry_q <= 1'b0;
        ovf_q   <= 1'b0;
      end else if (bus.enable_i && trig_re) begin
        out_q   <= out_d;
        carry_q <= carry_d;
        if (carry_d) begin
          ovf_q <= 1'b1;
        end
      end else begin
        carry_q <= 1'b0;
      end
    end
  end

  assign bus.out_o   = out_q;
  assign bus.carry_o = carry_q;
  assign bus.ovf_o   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_counter_ext.sv
// ----------------------------------------------------------------------------
// tb_counter_ext : table-driven scoreboard bench for counter_ext  (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module tb_counter_ext;

  localparam int WIDTH      = 8;
  localparam int STEP_WIDTH = 8;

  typedef struct {
    logic [95:0] name;
    logic        rst_n, en, trig, dir, sw, stw, mode;
    logic [7:0]  start, step, mn, mx;
    logic [7:0]  eout;
    logic        ec, eov;
  } vec_t;

  typedef struct packed {
    logic [95:0] name;
    logic [7:0]  out;
    logic        c;
    logic        ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic prev_carry = 1'b0;

  logic [7:0] cfg_start = 8'd10;
  logic [7:0] cfg_step  = 8'd1;
  logic [7:0] cfg_min   = 8'd0;
  logic [7:0] cfg_max   = 8'd255;
  logic       cfg_mode  = 1'b0;

  vec_t vecs[$];
  exp_t sb[$];

  counter_ext_if #(.WIDTH(WIDTH), .STEP_WIDTH(STEP_WIDTH)) bus ();

  counter_ext #(.WIDTH(WIDTH), .STEP_WIDTH(STEP_WIDTH)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [95:0] nm, input logic r, e, t, d, s, st,
                              input logic [7:0] eo, input logic ec, eov);
    vec_t v;
    v.name = nm; v.rst_n = r; v.en = e; v.trig = t; v.dir = d; v.sw = s; v.stw = st;
    v.mode = cfg_mode; v.start = cfg_start; v.step = cfg_step; v.mn = cfg_min; v.mx = cfg_max;
    v.eout = eo; v.ec = ec; v.eov = eov;
    return v;
  endfunction

  function automatic void add(input logic [95:0] nm, input logic r, e, t, d, s, st,
                              input logic [7:0] eo, input logic ec, eov);
    vecs.push_back(mk(nm, r, e, t, d, s, st, eo, ec, eov));
  endfunction

  task automatic apply(input vec_t v);
    exp_t x;
    @(negedge clk);
    rst_n          = v.rst_n;
    bus.enable_i   = v.en;
    bus.trigger_i  = v.trig;
    bus.dir_i      = v.dir;
    bus.START_WSTB = v.sw;
    bus.STEP_WSTB  = v.stw;
    bus.MODE       = v.mode;
    bus.START      = v.start;
    bus.STEP       = v.step;
    bus.MIN        = v.mn;
    bus.MAX        = v.mx;
    sb.push_back('{name: v.name, out: v.eout, c: v.ec, ov: v.eov});
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: queue empty, expected one entry");
    end else begin
      x = sb.pop_front();
      if (bus.out_o !== x.out || bus.carry_o !== x.c || bus.ovf_o !== x.ov) begin
        errors++;
        $display("FAIL %0s: got out=%0d carry=%0b ovf=%0b, expected out=%0d carry=%0b ovf=%0b",
                 x.name, bus.out_o, bus.carry_o, bus.ovf_o, x.out, x.c, x.ov);
      end
    end
    checks++;
    if (prev_carry && bus.carry_o) begin
      errors++;
      $display("FAIL carry_twice: got carry=1 on consecutive cycles, expected a single-cycle pulse");
    end
    prev_carry = bus.carry_o;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100us, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.enable_i = 1'b0; bus.trigger_i = 1'b0; bus.dir_i = 1'b0;
    bus.START_WSTB = 1'b0; bus.STEP_WSTB = 1'b0; bus.MODE = 1'b0;
    bus.START = '0; bus.STEP = '0; bus.MIN = '0; bus.MAX = '1;

    // name,            rst en tr dir sw stw  out  c  ov
    add("reset",          0, 0, 0, 0, 0, 0,  8'd0,   0, 0);
    add("reset",          0, 0, 0, 0, 0, 0,  8'd0,   0, 0);
    add("reset",          0, 0, 0, 0, 0, 0,  8'd0,   0, 0);
    add("post_reset",     1, 0, 0, 0, 0, 0,  8'd0,   0, 0);
    add("enable_load",    1, 1, 0, 0, 0, 0,  8'd10,  0, 0);
    add("enable_hold",    1, 1, 0, 0, 0, 0,  8'd10,  0, 0);

    cfg_min = 8'd0; cfg_max = 8'd15; cfg_step = 8'd4; cfg_mode = 1'b0; cfg_start = 8'd12;
    add("step_wr",        1, 1, 0, 0, 0, 1,  8'd10,  0, 0);
    add("start_wr",       1, 1, 0, 0, 1, 0,  8'd12,  0, 0);
    add("up_wrap",        1, 1, 1, 0, 0, 0,  8'd0,   1, 1);
    add("up_wrap_after",  1, 1, 0, 0, 0, 0,  8'd0,   0, 1);

    cfg_min = 8'd5; cfg_max = 8'd9; cfg_step = 8'd2; cfg_start = 8'd6;
    add("dn_load",        1, 1, 0, 1, 1, 1,  8'd6,   0, 0);
    add("dn_wrap",        1, 1, 1, 1, 0, 0,  8'd9,   1, 1);
    add("dn_wrap_low",    1, 1, 0, 1, 0, 0,  8'd9,   0, 1);
    add("dn_plain",       1, 1, 1, 1, 0, 0,  8'd7,   0, 1);
    add("dn_plain_low",   1, 1, 0, 1, 0, 0,  8'd7,   0, 1);

    cfg_mode = 1'b1; cfg_min = 8'd0; cfg_max = 8'd100; cfg_step = 8'd30; cfg_start = 8'd80;
    add("sat_load",       1, 1, 0, 0, 1, 1,  8'd80,  0, 0);
    add("sat_up_clamp",   1, 1, 1, 0, 0, 0,  8'd100, 1, 1);
    add("sat_low",        1, 1, 0, 0, 0, 0,  8'd100, 0, 1);
    add("sat_up_again",   1, 1, 1, 0, 0, 0,  8'd100, 0, 1);
    add("sat_low",        1, 1, 0, 0, 0, 0,  8'd100, 0, 1);
    add("sat_dn_70",      1, 1, 1, 1, 0, 0,  8'd70,  0, 1);
    add("sat_low",        1, 1, 0, 1, 0, 0,  8'd70,  0, 1);
    add("sat_dn_40",      1, 1, 1, 1, 0, 0,  8'd40,  0, 1);
    add("sat_low",        1, 1, 0, 1, 0, 0,  8'd40,  0, 1);
    add("sat_dn_10",      1, 1, 1, 1, 0, 0,  8'd10,  0, 1);
    add("sat_low",        1, 1, 0, 1, 0, 0,  8'd10,  0, 1);
    add("sat_dn_clamp",   1, 1, 1, 1, 0, 0,  8'd0,   1, 1);
    add("sat_low",        1, 1, 0, 1, 0, 0,  8'd0,   0, 1);
    add("sat_dn_again",   1, 1, 1, 1, 0, 0,  8'd0,   0, 1);
    add("sat_low",        1, 1, 0, 1, 0, 0,  8'd0,   0, 1);

    cfg_mode = 1'b0; cfg_min = 8'd0; cfg_max = 8'd255; cfg_start = 8'd7; cfg_step = 8'd1;
    add("load7",          1, 1, 0, 0, 1, 1,  8'd7,   0, 0);
    add("load_vs_trig",   1, 1, 1, 0, 1, 0,  8'd7,   0, 0);
    add("load_vs_low",    1, 1, 0, 0, 0, 0,  8'd7,   0, 0);
    cfg_step = 8'd3;
    add("step_vs_trig",   1, 1, 1, 0, 0, 1,  8'd8,   0, 0);
    add("step_low",       1, 1, 0, 0, 0, 0,  8'd8,   0, 0);
    add("new_step",       1, 1, 1, 0, 0, 0,  8'd11,  0, 0);
    add("new_step_low",   1, 1, 0, 0, 0, 0,  8'd11,  0, 0);

    add("en_fall",        1, 0, 0, 0, 0, 0,  8'd11,  0, 0);
    add("gated_trig",     1, 0, 1, 0, 0, 0,  8'd11,  0, 0);
    add("gated_low",      1, 0, 0, 0, 0, 0,  8'd11,  0, 0);
    add("gated_trig2",    1, 0, 1, 0, 0, 0,  8'd11,  0, 0);

    cfg_mode = 1'b1; cfg_min = 8'd0; cfg_max = 8'd100; cfg_step = 8'd30; cfg_start = 8'd70;
    add("en_reload",      1, 1, 0, 0, 0, 1,  8'd70,  0, 0);
    add("sat_exact",      1, 1, 1, 0, 0, 0,  8'd100, 1, 1);
    add("sat_exact_low",  1, 1, 0, 0, 0, 0,  8'd100, 0, 1);
    add("ovf_en_off",     1, 0, 0, 0, 0, 0,  8'd100, 0, 1);
    add("ovf_en_clear",   1, 1, 0, 0, 0, 0,  8'd70,  0, 0);

    foreach (vecs[i]) apply(vecs[i]);

    // Reset mid-count with trigger held high through release: the enable edge wins, no count
    apply(mk("rst_mid",      0, 1, 1, 0, 0, 0, 8'd0,  0, 0));
    apply(mk("rst_hold",     0, 1, 1, 0, 0, 0, 8'd0,  0, 0));
    apply(mk("rst_release",  1, 1, 1, 0, 0, 0, 8'd70, 0, 0));
    apply(mk("trig_held",    1, 1, 1, 0, 0, 0, 8'd70, 0, 0));
    apply(mk("trig_drop",    1, 1, 0, 0, 0, 0, 8'd70, 0, 0));
    // step register returns to 1 after reset
    apply(mk("trig_toggle",  1, 1, 1, 0, 0, 0, 8'd71, 0, 0));
    apply(mk("trig_toggle0", 1, 1, 0, 0, 0, 0, 8'd71, 0, 0));

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
